// File: rtl/piso_tx_pkg.sv
// Shared definitions for the serial transmit/receive pair: default word width,
// FSM state encoding and the width helper used to size the bit counter.
package piso_tx_pkg;

  localparam int WIDE_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: loads a WIDE-bit word over a valid/ready
// handshake and shifts it out one bit per sh-enabled clock, MSB or LSB first.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDE      = WIDE_DEF,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WIDE-1:0] go,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            sh,
  output logic            sout,
  output logic            sout_valid,
  output logic            frame_start,
  output logic            busy
);

  localparam int CNT_W = clog2(WIDE);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDE-1:0]   r_shreg;
  logic [WIDE-1:0]   w_shreg_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_shift;
  logic              w_last;
  logic              w_load;
  logic              w_out_bit;
  logic [WIDE-1:0]   w_shifted;

  assign w_shift    = (r_state == SHIFT) && sh;
  assign w_last     = (r_cnt == CNT_W'(WIDE - 1));
  assign load_ready = (r_state == IDLE) || (w_shift && w_last);
  assign w_load     = load_valid && load_ready;

  // Move one place toward whichever end drives sout, zero-filling behind.
  assign w_shifted  = LSB_FIRST ? {1'b0, r_shreg[WIDE-1:1]}
                                : {r_shreg[WIDE-2:0], 1'b0};
  assign w_out_bit  = LSB_FIRST ? r_shreg[0] : r_shreg[WIDE-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    if (w_load) begin
      w_state_nxt = SHIFT;
      w_shreg_nxt = go;
      w_cnt_nxt   = '0;
    end else if (w_shift) begin
      w_shreg_nxt = w_shifted;
      if (w_last) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    sout        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    busy        = 1'b0;
    if (r_state == SHIFT) begin
      sout        = w_out_bit;
      sout_valid  = sh;
      frame_start = sh && (r_cnt == '0);
      busy        = 1'b1;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: MSB-first instance checked cycle by cycle, plus an
// LSB-first instance sharing the same stimulus for the bit-order case.
module tb_piso_tx;

  logic       clk;
  logic       reset;
  logic [3:0] go;
  logic       load_valid;
  logic       sh;

  logic m_ready, m_sout, m_vld, m_fs, m_busy;
  logic l_ready, l_sout, l_vld, l_fs, l_busy;

  int n_tests;
  int n_fail;

  piso_tx #(.WIDE(4), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .reset(reset), .go(go), .load_valid(load_valid),
    .load_ready(m_ready), .sh(sh), .sout(m_sout), .sout_valid(m_vld),
    .frame_start(m_fs), .busy(m_busy)
  );

  piso_tx #(.WIDE(4), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .go(go), .load_valid(load_valid),
    .load_ready(l_ready), .sh(sh), .sout(l_sout), .sout_valid(l_vld),
    .frame_start(l_fs), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one cycle of MSB-instance outputs at negedge, then advance past the edge.
  task automatic exp_cyc(input string tag, input logic e_sout, input logic e_vld,
                         input logic e_fs, input logic e_busy, input logic e_lr);
    @(negedge clk);
    check({tag, ".sout"},  32'(m_sout),  32'(e_sout));
    check({tag, ".vld"},   32'(m_vld),   32'(e_vld));
    check({tag, ".fs"},    32'(m_fs),    32'(e_fs));
    check({tag, ".busy"},  32'(m_busy),  32'(e_busy));
    check({tag, ".ready"}, 32'(m_ready), 32'(e_lr));
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input string tag, input logic [3:0] w);
    go         = w;
    load_valid = 1'b1;
    sh         = 1'b1;
    @(negedge clk);
    check({tag, ".ld_ready"}, 32'(m_ready), 32'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    go         = 4'b0000;
    load_valid = 1'b0;
    sh         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst.shreg", 32'(dut.r_shreg), 32'd0);
    check("rst.cnt",   32'(dut.r_cnt),   32'd0);
    exp_cyc("rst", 0, 0, 0, 0, 1);

    // Basic MSB-first word 1101
    load_word("t1", 4'b1101);
    exp_cyc("t1b0", 1, 1, 1, 1, 0);
    exp_cyc("t1b1", 1, 1, 0, 1, 0);
    exp_cyc("t1b2", 0, 1, 0, 1, 0);
    exp_cyc("t1b3", 1, 1, 0, 1, 1);
    exp_cyc("t1idle", 0, 0, 0, 0, 1);

    // Stall for three cycles mid-word
    load_word("t2", 4'b1001);
    exp_cyc("t2b0", 1, 1, 1, 1, 0);
    exp_cyc("t2b1", 0, 1, 0, 1, 0);
    sh = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2stall.cnt", 32'(dut.r_cnt), 32'd2);
      exp_cyc("t2stall", 0, 0, 0, 1, 0);
    end
    sh = 1'b1;
    exp_cyc("t2b2", 0, 1, 0, 1, 0);
    exp_cyc("t2b3", 1, 1, 0, 1, 1);
    exp_cyc("t2idle", 0, 0, 0, 0, 1);

    // Back-to-back words 1101 then 0100
    load_word("t3", 4'b1101);
    go         = 4'b0100;
    load_valid = 1'b1;
    exp_cyc("t3b0", 1, 1, 1, 1, 0);
    exp_cyc("t3b1", 1, 1, 0, 1, 0);
    exp_cyc("t3b2", 0, 1, 0, 1, 0);
    exp_cyc("t3b3", 1, 1, 0, 1, 1);
    load_valid = 1'b0;
    exp_cyc("t3b4", 0, 1, 1, 1, 0);
    exp_cyc("t3b5", 1, 1, 0, 1, 0);
    exp_cyc("t3b6", 0, 1, 0, 1, 0);
    exp_cyc("t3b7", 0, 1, 0, 1, 1);
    exp_cyc("t3idle", 0, 0, 0, 0, 1);

    // Load attempt while busy is ignored
    load_word("t4", 4'b1010);
    exp_cyc("t4b0", 1, 1, 1, 1, 0);
    go         = 4'b0000;
    load_valid = 1'b1;
    exp_cyc("t4b1", 0, 1, 0, 1, 0);
    exp_cyc("t4b2", 1, 1, 0, 1, 0);
    load_valid = 1'b0;
    exp_cyc("t4b3", 0, 1, 0, 1, 1);
    exp_cyc("t4idle", 0, 0, 0, 0, 1);

    // Reset during bit 2, then clean restart
    load_word("t5", 4'b1101);
    exp_cyc("t5b0", 1, 1, 1, 1, 0);
    exp_cyc("t5b1", 1, 1, 0, 1, 0);
    reset = 1'b1;
    @(negedge clk);
    check("t5pre.busy", 32'(m_busy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5rst.shreg", 32'(dut.r_shreg), 32'd0);
    exp_cyc("t5rst", 0, 0, 0, 0, 1);
    go         = 4'b1111;
    load_valid = 1'b1;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    load_valid = 1'b0;
    exp_cyc("t5dom", 0, 0, 0, 0, 1);
    load_word("t5re", 4'b0110);
    exp_cyc("t5b0r", 0, 1, 1, 1, 0);
    exp_cyc("t5b1r", 1, 1, 0, 1, 0);
    exp_cyc("t5b2r", 1, 1, 0, 1, 0);
    exp_cyc("t5b3r", 0, 1, 0, 1, 1);
    exp_cyc("t5idle", 0, 0, 0, 0, 1);

    // LSB-first instance: 1010 goes out as 0,1,0,1
    go         = 4'b1010;
    load_valid = 1'b1;
    sh         = 1'b1;
    @(negedge clk);
    check("t6.ld_ready", 32'(l_ready), 32'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    begin
      logic [3:0] lsb_exp;
      lsb_exp = 4'b1010;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("t6.sout",  32'(l_sout),  32'(lsb_exp[k]));
        check("t6.vld",   32'(l_vld),   32'd1);
        check("t6.fs",    32'(l_fs),    32'(k == 0));
        check("t6.ready", 32'(l_ready), 32'(k == 3));
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    check("t6idle.busy", 32'(l_busy), 32'd0);
    check("t6idle.vld",  32'(l_vld),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
